mux_4_1_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 4:1 MUX output line among four requesters. It drives `Select_In` and `Enable_In` of a `MUX_4_1` instance. It grants one requester at a time, holds the grant for at most `MAX_BURST` cycles under contention, and tristates the shared line when idle. It sits between the four data sources' request logic and the MUX.

---
 rtl/mux_ctrl_pkg.sv | 17 +
 rtl/rr_priority_pick.sv | 31 +++
 rtl/mux_4_1_rr_arbiter.sv | 119 +++++++++++
 tb/tb_mux_4_1_rr_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mux_ctrl_pkg.sv
// Shared definitions for the 4:1 MUX round-robin arbiter.
//   state_t  : arbiter FSM encodings (ST_IDLE, ST_GRANT)
//   NUM_REQ  : number of requesters sharing the MUX line
//   SEL_W    : width of the requester index / MUX select
//   BURST_W  : width of the burst counter
package mux_ctrl_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;
    localparam int BURST_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin search.
//   req    : request vector to search
//   ptr    : index of the most recent owner; search starts at ptr+1, wraps 3->0
//   found  : at least one bit of req is set
//   winner : first requesting index at or after ptr+1 (ptr itself is checked last)
module rr_priority_pick
    import mux_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   winner
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        // SEL_W-bit addition wraps the search naturally modulo NUM_REQ.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter sharing a MUX_4_1 output line among four requesters.
//   Clock_In   : clock, rising edge
//   Reset_In   : asynchronous active-high reset
//   Request_In : per-requester request bits
//   Grant_Out  : registered one-hot grant, zero when idle
//   Select_Out : registered index of the owner (held while idle)
//   Enable_Out : registered, high while a grant is active
//   Busy_Out   : copy of Enable_Out for status
// An owner keeps the line for at most MAX_BURST cycles while another
// requester waits; a sole requester keeps it indefinitely.
module mux_4_1_rr_arbiter
    import mux_ctrl_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic               Clock_In,
    input  logic               Reset_In,
    input  logic [NUM_REQ-1:0] Request_In,
    output logic [NUM_REQ-1:0] Grant_Out,
    output logic [SEL_W-1:0]   Select_Out,
    output logic               Enable_Out,
    output logic               Busy_Out
);

    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);

    state_t               state, state_nxt;
    logic [SEL_W-1:0]     last_ptr, last_ptr_nxt;
    logic [BURST_W-1:0]   burst_cnt, burst_nxt;
    logic [NUM_REQ-1:0]   grant_nxt;
    logic [SEL_W-1:0]     sel_nxt;
    logic                 en_nxt;

    logic [NUM_REQ-1:0]   pick_req;
    logic                 pick_found;
    logic [SEL_W-1:0]     pick_idx;
    logic                 own_req;
    logic                 burst_expired;
    logic                 take;

    // While granted, search only the other requesters; last_ptr equals the
    // owner then, so the same picker serves both idle and handover cases.
    assign pick_req      = (state == ST_GRANT) ? (Request_In & ~Grant_Out) : Request_In;
    assign own_req       = Request_In[Select_Out];
    assign burst_expired = (burst_cnt == BURST_LIMIT);

    rr_priority_pick u_pick (
        .req    (pick_req),
        .ptr    (last_ptr),
        .found  (pick_found),
        .winner (pick_idx)
    );

    always_comb begin
        state_nxt    = state;
        grant_nxt    = Grant_Out;
        sel_nxt      = Select_Out;
        en_nxt       = Enable_Out;
        last_ptr_nxt = last_ptr;
        burst_nxt    = burst_cnt;
        take         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pick_found) take = 1'b1;
            end
            ST_GRANT: begin
                // Release wins over expiry when both happen on the same edge.
                if (!own_req) begin
                    if (pick_found) begin
                        take = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        grant_nxt = '0;
                        en_nxt    = 1'b0;
                        burst_nxt = '0;
                    end
                end else if (burst_expired) begin
                    if (pick_found) take = 1'b1;
                    else            burst_nxt = BURST_W'(1);
                end else begin
                    burst_nxt = burst_cnt + BURST_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (take) begin
            state_nxt           = ST_GRANT;
            grant_nxt           = '0;
            grant_nxt[pick_idx] = 1'b1;
            sel_nxt             = pick_idx;
            en_nxt              = 1'b1;
            last_ptr_nxt        = pick_idx;
            burst_nxt           = BURST_W'(1);
        end
    end

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state      <= ST_IDLE;
            Grant_Out  <= '0;
            Select_Out <= '0;
            Enable_Out <= 1'b0;
            last_ptr   <= SEL_W'(NUM_REQ - 1);
            burst_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            Grant_Out  <= grant_nxt;
            Select_Out <= sel_nxt;
            Enable_Out <= en_nxt;
            last_ptr   <= last_ptr_nxt;
            burst_cnt  <= burst_nxt;
        end
    end

    assign Busy_Out = Enable_Out;

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
module tb_mux_4_1_rr_arbiter;

    localparam int MAXB   = 2;
    localparam int WAIT_B = 3 * MAXB + 3;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       en;
    logic       busy;

    int n_chk;
    int n_fail;

    mux_4_1_rr_arbiter #(.MAX_BURST(MAXB)) dut (
        .Clock_In   (clk),
        .Reset_In   (rst),
        .Request_In (req),
        .Grant_Out  (grant),
        .Select_Out (sel),
        .Enable_Out (en),
        .Busy_Out   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] s, input logic e);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".sel"},   32'(sel),   32'(s));
        check({tag, ".en"},    32'(en),    32'(e));
        check({tag, ".busy"},  32'(busy),  32'(e));
    endtask

    int          wcnt [4];
    int          max_wait;
    logic [3:0]  exp_g;
    logic [1:0]  exp_idx;
    logic [3:0]  cur_req;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        req    = 4'b0000;

        // Reset state
        step();
        check_out("reset", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;

        // Single request, then release back to idle (select holds)
        req = 4'b0100;
        step();
        check_out("single", 4'b0100, 2'd2, 1'b1);
        req = 4'b0000;
        step();
        check_out("single_rel", 4'b0000, 2'd2, 1'b0);

        // All requesting after reset: pairs 0,0,1,1,2,2,3,3,0,0
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            step();
            exp_idx = 2'((k / 2) % 4);
            exp_g   = 4'b0001 << exp_idx;
            check($sformatf("rot%0d", k), 32'(grant), 32'(exp_g));
            check($sformatf("rot%0d.en", k), 32'(en), 32'd1);
        end

        // Early release: owner 1 held 3 cycles, drops with 3 pending, 2 skipped
        do_reset();
        req = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("own1_%0d", k), 32'(grant), 32'h2);
        end
        req = 4'b1000;
        step();
        check_out("handover", 4'b1000, 2'd3, 1'b1);
        req = 4'b0000;
        step();
        check_out("idle3", 4'b0000, 2'd3, 1'b0);

        // Sole requester 0 for 20 cycles: burst restarts, no glitch
        req = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            step();
            check($sformatf("sole%0d", k), 32'(grant), 32'h1);
            check($sformatf("sole%0d.en", k), 32'(en), 32'd1);
        end
        req = 4'b0000;
        step();

        // Async reset mid-grant (last owner 0, so 2 wins over 3? no: search 1,2 -> 2)
        req = 4'b0100;
        step();
        check_out("pre_arst", 4'b0100, 2'd2, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_out("arst", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        req = 4'b1100;
        step();
        check_out("post_arst", 4'b0100, 2'd2, 1'b1);

        // Random stimulus invariants
        do_reset();
        for (int i = 0; i < 4; i++) wcnt[i] = 0;
        max_wait = 0;
        for (int c = 0; c < 2000; c++) begin
            cur_req = 4'($urandom_range(0, 15));
            req = cur_req;
            step();
            check("inv_onehot", 32'($onehot0(grant)), 32'd1);
            check("inv_busy", 32'(busy), 32'(en));
            check("inv_en", 32'(en), 32'(grant != 4'b0000));
            if (grant != 4'b0000) begin
                exp_idx = 2'd0;
                for (int i = 0; i < 4; i++) if (grant[i]) exp_idx = 2'(i);
                check("inv_sel", 32'(sel), 32'(exp_idx));
            end
            for (int i = 0; i < 4; i++) begin
                if (cur_req[i] && !grant[i]) wcnt[i]++;
                else                         wcnt[i] = 0;
                if (wcnt[i] > max_wait) max_wait = wcnt[i];
            end
            // Bias towards holding requests so contention builds up
            if (($urandom % 4) != 0) begin
                cur_req = cur_req | 4'($urandom_range(0, 15));
                req = cur_req;
                step();
                check("inv_onehot2", 32'($onehot0(grant)), 32'd1);
                for (int i = 0; i < 4; i++) begin
                    if (cur_req[i] && !grant[i]) wcnt[i]++;
                    else                         wcnt[i] = 0;
                    if (wcnt[i] > max_wait) max_wait = wcnt[i];
                end
            end
        end
        check("max_wait_ok", 32'(max_wait <= WAIT_B), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
